// File: rtl/dphy_lane_hs_sequencer.sv
//-----------------------------------------------------------------------------
// dphy_lane_hs_sequencer
//
// Sequences one MIPI D-PHY data lane through a high-speed burst:
//   STOP (LP-11) -> LPX (LP-01) -> PREPARE (LP-00) -> ZERO (HS 0x00)
//   -> SYNC (HS 0xB8) -> DATA (payload) -> TRAIL (inverted last bit)
//   -> EXIT (LP-11) -> STOP.
// The timed states share one 8-bit down-counter, loaded with (duration - 1)
// on entry and left when it reaches zero.
//
// Parameters (all durations in clk_i cycles, legal range 1..255):
//   T_LPX        LP-01 request duration
//   T_HS_PREPARE LP-00 prepare duration
//   T_HS_ZERO    HS-zero duration
//   T_HS_TRAIL   HS-trail duration
//   T_HS_EXIT    post-burst LP-11 hold
//
// Ports:
//   clk_i         byte clock, rising edge
//   rst_i         synchronous active-high reset
//   tx_req_i      burst request, only looked at in STOP
//   data_i        payload byte, bit 0 serialized first
//   data_valid_i  data_i valid
//   last_i        data_i is the final payload byte (qualified by valid)
//   data_ready_o  byte on data_i is taken this cycle when valid is high
//   hs_en_o       HS driver enable
//   hs_data_o     byte to the lane serializer
//   lp_p_o/lp_n_o LP line levels
//   busy_o        high whenever the lane is not in STOP
//   underrun_o    one-cycle pulse on the first TRAIL cycle of a burst that
//                 ended because no payload byte was offered
//-----------------------------------------------------------------------------
module dphy_lane_hs_sequencer #(
  parameter int T_LPX        = 2,
  parameter int T_HS_PREPARE = 2,
  parameter int T_HS_ZERO    = 3,
  parameter int T_HS_TRAIL   = 2,
  parameter int T_HS_EXIT    = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_req_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  input  logic       last_i,
  output logic       data_ready_o,
  output logic       hs_en_o,
  output logic [7:0] hs_data_o,
  output logic       lp_p_o,
  output logic       lp_n_o,
  output logic       busy_o,
  output logic       underrun_o
);

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_LPX     = 3'd1,
    ST_PREPARE = 3'd2,
    ST_ZERO    = 3'd3,
    ST_SYNC    = 3'd4,
    ST_DATA    = 3'd5,
    ST_TRAIL   = 3'd6,
    ST_EXIT    = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  // Counter load values: a state lasting N cycles starts at N-1.
  localparam logic [7:0] LPX_LOAD     = 8'(T_LPX - 1);
  localparam logic [7:0] PREPARE_LOAD = 8'(T_HS_PREPARE - 1);
  localparam logic [7:0] ZERO_LOAD    = 8'(T_HS_ZERO - 1);
  localparam logic [7:0] TRAIL_LOAD   = 8'(T_HS_TRAIL - 1);
  localparam logic [7:0] EXIT_LOAD    = 8'(T_HS_EXIT - 1);

  // Trail holds the opposite of the final transmitted bit (MSB goes last).
  function automatic logic [7:0] trail_byte(input logic [7:0] last_byte);
    return {8{~last_byte[7]}};
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic       underrun_q, underrun_d;

  logic       ready_s;
  logic       accept_s;
  logic       cnt_done_s;

  assign ready_s    = ((state_q == ST_SYNC) || (state_q == ST_DATA)) && !last_q;
  assign accept_s   = ready_s && data_valid_i;
  assign cnt_done_s = (cnt_q == 8'd0);

  // State, counter and payload registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_STOP;
      cnt_q      <= 8'd0;
      data_q     <= 8'h00;
      last_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      last_q     <= last_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state, counter and payload capture logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    last_d     = last_q;
    underrun_d = 1'b0;

    case (state_q)
      ST_STOP: begin
        if (tx_req_i) begin
          state_d = ST_LPX;
          cnt_d   = LPX_LOAD;
          last_d  = 1'b0;
        end else begin
          state_d = ST_STOP;
        end
      end

      ST_LPX: begin
        if (cnt_done_s) begin
          state_d = ST_PREPARE;
          cnt_d   = PREPARE_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_PREPARE: begin
        if (cnt_done_s) begin
          state_d = ST_ZERO;
          cnt_d   = ZERO_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_ZERO: begin
        if (cnt_done_s) begin
          // The sync byte is parked in data_q so a zero-payload burst trails
          // on the MSB of 0xB8.
          state_d = ST_SYNC;
          cnt_d   = 8'd0;
          data_d  = SYNC_BYTE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_SYNC, ST_DATA: begin
        if (last_q) begin
          state_d = ST_TRAIL;
          cnt_d   = TRAIL_LOAD;
        end else if (accept_s) begin
          state_d = ST_DATA;
          data_d  = data_i;
          last_d  = last_i;
        end else begin
          // No byte offered while ready: end the burst early.
          state_d    = ST_TRAIL;
          cnt_d      = TRAIL_LOAD;
          underrun_d = 1'b1;
        end
      end

      ST_TRAIL: begin
        if (cnt_done_s) begin
          state_d = ST_EXIT;
          cnt_d   = EXIT_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_EXIT: begin
        if (cnt_done_s) begin
          state_d = ST_STOP;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_STOP;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Lane output decode from registered state and payload only.
  always_comb begin
    lp_p_o       = 1'b1;
    lp_n_o       = 1'b1;
    hs_en_o      = 1'b0;
    hs_data_o    = 8'h00;
    data_ready_o = 1'b0;
    busy_o       = (state_q != ST_STOP);

    case (state_q)
      ST_STOP, ST_EXIT: begin
        lp_p_o = 1'b1;
        lp_n_o = 1'b1;
      end
      ST_LPX: begin
        lp_p_o = 1'b0;
        lp_n_o = 1'b1;
      end
      ST_PREPARE: begin
        lp_p_o = 1'b0;
        lp_n_o = 1'b0;
      end
      ST_ZERO: begin
        lp_p_o    = 1'b0;
        lp_n_o    = 1'b0;
        hs_en_o   = 1'b1;
        hs_data_o = 8'h00;
      end
      ST_SYNC: begin
        lp_p_o       = 1'b0;
        lp_n_o       = 1'b0;
        hs_en_o      = 1'b1;
        hs_data_o    = SYNC_BYTE;
        data_ready_o = ready_s;
      end
      ST_DATA: begin
        lp_p_o       = 1'b0;
        lp_n_o       = 1'b0;
        hs_en_o      = 1'b1;
        hs_data_o    = data_q;
        data_ready_o = ready_s;
      end
      ST_TRAIL: begin
        lp_p_o    = 1'b0;
        lp_n_o    = 1'b0;
        hs_en_o   = 1'b1;
        hs_data_o = trail_byte(data_q);
      end
      default: begin
        lp_p_o = 1'b1;
        lp_n_o = 1'b1;
      end
    endcase
  end

  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_dphy_lane_hs_sequencer.sv
//-----------------------------------------------------------------------------
// Bench for dphy_lane_hs_sequencer. Expected lane traces are built from the
// burst rules as a per-cycle list of lane observations; the DUT is then
// played against the same per-cycle input list and every cycle compared.
// Observation word: {lp_p, lp_n, hs_en, hs_data[7:0], busy, underrun, ready}.
//-----------------------------------------------------------------------------
module tb_dphy_lane_hs_sequencer;

  localparam int T_LPX   = 2;
  localparam int T_PREP  = 2;
  localparam int T_ZERO  = 3;
  localparam int T_TRAIL = 2;
  localparam int T_EXIT  = 2;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       tx_req_i;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       last_i;
  logic       data_ready_o;
  logic       hs_en_o;
  logic [7:0] hs_data_o;
  logic       lp_p_o;
  logic       lp_n_o;
  logic       busy_o;
  logic       underrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  logic        drv_tx[$];
  logic        drv_v[$];
  logic [7:0]  drv_d[$];
  logic        drv_l[$];
  logic [7:0]  fixed_bytes[$];

  dphy_lane_hs_sequencer #(
    .T_LPX(T_LPX), .T_HS_PREPARE(T_PREP), .T_HS_ZERO(T_ZERO),
    .T_HS_TRAIL(T_TRAIL), .T_HS_EXIT(T_EXIT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .tx_req_i(tx_req_i), .data_i(data_i),
    .data_valid_i(data_valid_i), .last_i(last_i), .data_ready_o(data_ready_o),
    .hs_en_o(hs_en_o), .hs_data_o(hs_data_o), .lp_p_o(lp_p_o), .lp_n_o(lp_n_o),
    .busy_o(busy_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] pk(input logic lp_p, input logic lp_n,
                                     input logic en, input logic [7:0] d,
                                     input logic busy, input logic und,
                                     input logic rdy);
    return {lp_p, lp_n, en, d, busy, und, rdy};
  endfunction

  function automatic logic [13:0] observe();
    return {lp_p_o, lp_n_o, hs_en_o, hs_data_o, busy_o, underrun_o, data_ready_o};
  endfunction

  task automatic clear_queues();
    exp_q.delete(); obs_q.delete(); drv_tx.delete();
    drv_v.delete(); drv_d.delete(); drv_l.delete(); fixed_bytes.delete();
  endtask

  // One cycle of expectation with explicit inputs.
  task automatic add(input logic [13:0] e, input logic tx, input logic v,
                     input logic [7:0] d, input logic l);
    exp_q.push_back(e); drv_tx.push_back(tx);
    drv_v.push_back(v); drv_d.push_back(d); drv_l.push_back(l);
  endtask

  // One cycle of expectation where the payload inputs must not matter.
  task automatic add_noise(input logic [13:0] e, input logic tx);
    add(e, tx, 1'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic append_idle(input int n);
    for (int i = 0; i < n; i++) add_noise(pk(1, 1, 0, 8'h00, 0, 0, 0), 1'b0);
  endtask

  // Expected trace of one burst, from the requesting STOP cycle to the last
  // EXIT cycle. Payload is offered while valid; the first ready cycle with
  // no byte offered ends the burst with an underrun.
  task automatic append_burst(input int nbytes, input int drop_after,
                              input int valid_pct, input bit tx_noise,
                              input bit exit_hold);
    logic [7:0] shown;
    logic       lastf;
    logic       und;
    logic       v;
    logic       l;
    logic [7:0] b;
    int         idx;
    add_noise(pk(1, 1, 0, 8'h00, 0, 0, 0), 1'b1);
    for (int i = 0; i < T_LPX; i++)
      add_noise(pk(0, 1, 0, 8'h00, 1, 0, 0), tx_noise ? 1'($urandom) : 1'b0);
    for (int i = 0; i < T_PREP; i++)
      add_noise(pk(0, 0, 0, 8'h00, 1, 0, 0), tx_noise ? 1'($urandom) : 1'b0);
    for (int i = 0; i < T_ZERO; i++)
      add_noise(pk(0, 0, 1, 8'h00, 1, 0, 0), tx_noise ? 1'($urandom) : 1'b0);
    shown = 8'hB8; lastf = 1'b0; und = 1'b0; idx = 0;
    while (1) begin
      if (lastf) begin
        add_noise(pk(0, 0, 1, shown, 1, 0, 0), tx_noise ? 1'($urandom) : 1'b0);
        break;
      end
      v = ((drop_after < 0) || (idx < drop_after)) &&
          (int'($urandom_range(99)) < valid_pct);
      if (v) begin
        b = (fixed_bytes.size() > 0) ? fixed_bytes.pop_front() : 8'($urandom);
        l = (idx == nbytes - 1);
        add(pk(0, 0, 1, shown, 1, 0, 1), tx_noise ? 1'($urandom) : 1'b0, 1'b1, b, l);
        shown = b; lastf = l; idx++;
      end else begin
        add(pk(0, 0, 1, shown, 1, 0, 1), tx_noise ? 1'($urandom) : 1'b0,
            1'b0, 8'($urandom), 1'($urandom));
        und = 1'b1;
        break;
      end
    end
    for (int i = 0; i < T_TRAIL; i++)
      add_noise(pk(0, 0, 1, {8{~shown[7]}}, 1, (i == 0) && und, 0),
                tx_noise ? 1'($urandom) : 1'b0);
    for (int i = 0; i < T_EXIT; i++)
      add_noise(pk(1, 1, 0, 8'h00, 1, 0, 0), exit_hold);
  endtask

  // Plays the drive lists, one cycle each, and records what the lane showed.
  task automatic run_queue();
    obs_q.delete();
    for (int c = 0; c < exp_q.size(); c++) begin
      @(posedge clk); #1;
      tx_req_i = drv_tx[c]; data_valid_i = drv_v[c];
      data_i = drv_d[c]; last_i = drv_l[c];
      @(negedge clk);
      obs_q.push_back(observe());
    end
    @(posedge clk); #1;
    tx_req_i = 1'b0; data_valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tx_req_i = 1'b1; data_valid_i = 1'b1; data_i = 8'hA5; last_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (observe() !== pk(1, 1, 0, 8'h00, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", observe(), pk(1, 1, 0, 8'h00, 0, 0, 0));
    end
    @(posedge clk); #1; rst_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_stop: busy got %b expected 0", busy_o);
    end
    @(posedge clk); #1; tx_req_i = 1'b0; data_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({lp_p_o, lp_n_o, busy_o} !== 3'b011) begin
      n_fail++;
      $display("FAIL req_through_reset: lp/busy got %b expected 011", {lp_p_o, lp_n_o, busy_o});
    end
    @(posedge clk); #1; rst_i = 1'b1;
    @(posedge clk); #1; rst_i = 1'b0;
  endtask

  task automatic test_nominal();
    clear_queues();
    fixed_bytes.push_back(8'h11); fixed_bytes.push_back(8'h22); fixed_bytes.push_back(8'h83);
    append_burst(3, -1, 100, 1'b0, 1'b0);
    append_idle(1);
    run_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL nominal cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({obs_q[8][10:3], obs_q[11][10:3], obs_q[12][10:3], obs_q[16][2]} !== {8'hB8, 8'h83, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL nominal_markers: sync %h last %h trail %h busy16 %b", obs_q[8][10:3],
               obs_q[11][10:3], obs_q[12][10:3], obs_q[16][2]);
    end
  endtask

  task automatic test_single_byte();
    clear_queues();
    fixed_bytes.push_back(8'h05);
    append_burst(1, -1, 100, 1'b0, 1'b0);
    run_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_byte cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({obs_q[9][10:3], obs_q[9][0], obs_q[10][10:3], obs_q[11][10:3]} !== {8'h05, 1'b0, 8'hFF, 8'hFF}) begin
      n_fail++;
      $display("FAIL single_byte_markers: c9 %h rdy %b c10 %h c11 %h", obs_q[9][10:3], obs_q[9][0],
               obs_q[10][10:3], obs_q[11][10:3]);
    end
  endtask

  task automatic test_underrun_sync();
    clear_queues();
    append_burst(4, -1, 0, 1'b0, 1'b0);
    run_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL underrun_sync cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({obs_q[9][1], obs_q[10][1], obs_q[9][10:3], obs_q[10][10:3]} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL underrun_sync_markers: und9 %b und10 %b c9 %h c10 %h", obs_q[9][1], obs_q[10][1],
               obs_q[9][10:3], obs_q[10][10:3]);
    end
  endtask

  task automatic test_underrun_data();
    clear_queues();
    fixed_bytes.push_back(8'h7F);
    append_burst(5, 1, 100, 1'b0, 1'b0);
    run_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL underrun_data cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({obs_q[9][10:3], obs_q[10][1], obs_q[10][10:3]} !== {8'h7F, 1'b1, 8'hFF}) begin
      n_fail++;
      $display("FAIL underrun_data_markers: c9 %h und10 %b c10 %h", obs_q[9][10:3], obs_q[10][1],
               obs_q[10][10:3]);
    end
  endtask

  task automatic test_back_to_back();
    int stop_idx;
    clear_queues();
    append_burst(3, -1, 100, 1'b1, 1'b1);
    stop_idx = exp_q.size();
    append_burst(2, -1, 100, 1'b1, 1'b0);
    run_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({obs_q[stop_idx][2], obs_q[stop_idx + 1][13:12], obs_q[stop_idx + 1][2]} !== 4'b0011) begin
      n_fail++;
      $display("FAIL back_to_back_gap: stop busy %b next lp %b busy %b", obs_q[stop_idx][2],
               obs_q[stop_idx + 1][13:12], obs_q[stop_idx + 1][2]);
    end
  endtask

  task automatic test_random();
    clear_queues();
    for (int k = 0; k < 25; k++) begin
      append_burst(int'($urandom_range(1, 6)), -1, 85, 1'($urandom), 1'($urandom));
      append_idle(int'($urandom_range(0, 3)));
    end
    run_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL random cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    // Abort during ZERO (cycle 5 of the burst).
    @(posedge clk); #1; tx_req_i = 1'b1;
    @(posedge clk); #1; tx_req_i = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({hs_en_o, hs_data_o} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL abort_in_zero_pre: en/data got %b/%h expected 1/00", hs_en_o, hs_data_o);
    end
    @(posedge clk); #1; rst_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (observe() !== pk(1, 1, 0, 8'h00, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL abort_in_zero: got %h expected %h", observe(), pk(1, 1, 0, 8'h00, 0, 0, 0));
    end
    // Abort while a payload byte is on the lane (cycle 9).
    @(posedge clk); #1; tx_req_i = 1'b1;
    @(posedge clk); #1; tx_req_i = 1'b0; data_valid_i = 1'b1; data_i = 8'h5A; last_i = 1'b0;
    repeat (8) @(posedge clk);
    #1; rst_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({hs_en_o, hs_data_o} !== {1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL abort_in_data_pre: en/data got %b/%h expected 1/5a", hs_en_o, hs_data_o);
    end
    @(posedge clk); #1; rst_i = 1'b0; data_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (observe() !== pk(1, 1, 0, 8'h00, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL abort_in_data: got %h expected %h", observe(), pk(1, 1, 0, 8'h00, 0, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_single_byte();
    test_underrun_sync();
    test_underrun_data();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dphy_lane_hs_sequencer.md
DPHY_LANE_HS_SEQUENCER -- requirements
Module: dphy_lane_hs_sequencer

Interface
REQ-001 Parameter T_LPX, default 2: LP-01 (HS-request) duration in clk_i cycles, legal range 1..255.
REQ-002 Parameter T_HS_PREPARE, default 2: LP-00 (prepare) duration in cycles, legal range 1..255.
REQ-003 Parameter T_HS_ZERO, default 3: HS-zero duration in cycles, legal range 1..255.
REQ-004 Parameter T_HS_TRAIL, default 2: HS-trail duration in cycles, legal range 1..255.
REQ-005 Parameter T_HS_EXIT, default 2: post-burst LP-11 hold in cycles, legal range 1..255.
REQ-006 clk_i  input  1  the single byte clock; all logic is on the rising edge.
REQ-007 rst_i  input  1  synchronous, active-high reset.
REQ-008 tx_req_i  input  1  burst request, sampled only in STOP.
REQ-009 data_i  input  8  payload byte; serializer sends bit 0 first.
REQ-010 data_valid_i  input  1  data_i valid.
REQ-011 last_i  input  1  data_i is the final payload byte; qualified by data_valid_i.
REQ-012 data_ready_o  output  1  sequencer accepts data_i this cycle.
REQ-013 hs_en_o  output  1  HS driver enable.
REQ-014 hs_data_o  output  8  byte to the lane serializer.
REQ-015 lp_p_o, lp_n_o  output  1 each  LP line levels.
REQ-016 busy_o  output  1  high whenever state is not STOP.
REQ-017 underrun_o  output  1  one-cycle pulse when the burst is terminated by missing data.

Function
REQ-018 The FSM SHALL have states STOP, LPX, PREPARE, ZERO, SYNC, DATA, TRAIL and EXIT, with an 8-bit down-counter for the timed states.
REQ-019 Every output SHALL be a function of the registered state, counter, data_q and last_q only; there are no combinational input-to-output paths except data_ready_o, which depends only on state and last_q.
REQ-020 Each state SHALL drive the following outputs:
- STOP/EXIT: lp=11, hs_en=0.
- LPX: lp=01, hs_en=0.
- PREPARE: lp=00, hs_en=0.
- ZERO: lp=00, hs_en=1, hs_data=0x00.
- SYNC: lp=00, hs_en=1, hs_data=0xB8.
- DATA: lp=00, hs_en=1, hs_data=data_q.
- TRAIL: lp=00, hs_en=1, hs_data={8{~data_q[7]}}.
REQ-021 In STOP with tx_req_i=1, the FSM SHALL enter LPX at the next edge; tx_req_i is ignored in all other states.
REQ-022 LPX, PREPARE, ZERO, TRAIL and EXIT SHALL each last exactly their parameter's cycle count, then advance in the order LPX->PREPARE->ZERO->SYNC and TRAIL->EXIT->STOP.
REQ-023 SYNC SHALL last exactly 1 cycle and SHALL load data_q<=0xB8 on entry.
REQ-024 data_ready_o SHALL equal (state is SYNC or DATA) and not last_q; a byte is accepted when data_valid_i and data_ready_o are both high.
REQ-025 In SYNC or DATA, exactly one of the following SHALL occur at the edge:
- last_q=1 -> TRAIL.
- Accept -> DATA, with data_q<=data_i and last_q<=last_i.
- No accept -> TRAIL, with underrun_o pulsed high for the first TRAIL cycle.
REQ-026 An accepted byte SHALL appear on hs_data_o exactly one cycle after acceptance (latency 1).
REQ-027 A zero-payload burst (underrun in SYNC) SHALL produce trail bytes 0x00, because data_q[7] of 0xB8 is 1.
REQ-028 last_q SHALL clear on entry to LPX.
REQ-029 The minimum spacing between bursts SHALL be one STOP cycle.

Reset
REQ-030 rst_i=1 at any edge SHALL force the following values:
- state=STOP, counter=0, data_q=0x00, last_q=0.
- lp_p_o=lp_n_o=1, hs_en_o=0, hs_data_o=0x00.
- data_ready_o=0, busy_o=0, underrun_o=0.
REQ-031 Reset during a burst SHALL abort it immediately with no trail or exit sequence, and any in-flight byte SHALL be discarded.
REQ-032 tx_req_i held high through reset SHALL start a burst at the first edge after rst_i falls.

Verification
REQ-033 Default parameters, tx_req_i pulsed at cycle 0, bytes 0x11, 0x22, 0x83 (last) always valid -> the bench SHALL see the following sequence:
- Cycles 1-2: lp=01.
- Cycles 3-4: lp=00.
- Cycles 5-7: hs_data=0x00, hs_en=1.
- Cycle 8: hs_data=0xB8.
- Cycles 9-11: hs_data=0x11, 0x22, 0x83.
- Cycles 12-13: hs_data=0x00.
- Cycles 14-15: lp=11, hs_en=0.
- Cycle 16: busy_o=0.
REQ-034 Same setup with the single byte 0x05 (last) -> cycle 9 shows 0x05, cycles 10-11 show trail 0xFF, and data_ready_o=0 in cycle 9.
REQ-035 Burst with data_valid_i low from SYNC onward -> underrun_o=1 in cycle 9 only, and cycles 9-10 show trail 0x00.
REQ-036 Burst where valid drops after byte 0x7F (not last) -> the 0x7F cycle is followed by one underrun pulse and trail 0xFF.
REQ-037 rst_i asserted during ZERO -> on the next cycle lp=11, hs_en=0 and busy_o=0.
REQ-038 tx_req_i toggled during DATA and held high through EXIT -> the current burst is unaffected, one STOP cycle follows, then LPX.
